// File: rtl/cgra_pe_unit.sv
// Single CGRA processing element: executes one 64-bit configuration frame per cycle
// over mesh/RF/immediate/accumulator/scratchpad operands, with registered mesh and local outputs.
module cgra_pe_unit #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int SPM_DEPTH  = 256,
    parameter int RF_DEPTH   = 16,
    parameter int LIF_LEAK   = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [63:0]           config_frame,
    input  logic                  config_valid,
    input  logic [DATA_WIDTH-1:0] data_in_n,
    input  logic [DATA_WIDTH-1:0] data_in_e,
    input  logic [DATA_WIDTH-1:0] data_in_s,
    input  logic [DATA_WIDTH-1:0] data_in_w,
    input  logic                  valid_in_n,
    input  logic                  valid_in_e,
    input  logic                  valid_in_s,
    input  logic                  valid_in_w,
    output logic [DATA_WIDTH-1:0] data_out_n,
    output logic [DATA_WIDTH-1:0] data_out_e,
    output logic [DATA_WIDTH-1:0] data_out_s,
    output logic [DATA_WIDTH-1:0] data_out_w,
    output logic                  valid_out_n,
    output logic                  valid_out_e,
    output logic                  valid_out_s,
    output logic                  valid_out_w,
    output logic [DATA_WIDTH-1:0] data_out_local,
    output logic                  valid_out_local
);

    localparam int LW = DATA_WIDTH + 2;

    localparam logic [5:0] OP_ADD     = 6'd1;
    localparam logic [5:0] OP_SUB     = 6'd2;
    localparam logic [5:0] OP_MUL     = 6'd3;
    localparam logic [5:0] OP_MAC     = 6'd4;
    localparam logic [5:0] OP_AND     = 6'd5;
    localparam logic [5:0] OP_OR      = 6'd6;
    localparam logic [5:0] OP_XOR     = 6'd7;
    localparam logic [5:0] OP_SHL     = 6'd8;
    localparam logic [5:0] OP_SHR     = 6'd9;
    localparam logic [5:0] OP_CMP_GT  = 6'd10;
    localparam logic [5:0] OP_CMP_LT  = 6'd11;
    localparam logic [5:0] OP_CMP_EQ  = 6'd12;
    localparam logic [5:0] OP_LOAD    = 6'd13;
    localparam logic [5:0] OP_STORE   = 6'd14;
    localparam logic [5:0] OP_ACC_CLR = 6'd15;
    localparam logic [5:0] OP_PASS0   = 6'd16;
    localparam logic [5:0] OP_PASS1   = 6'd17;
    localparam logic [5:0] OP_LIF     = 6'd18;

    function automatic logic [DATA_WIDTH-1:0] src_mux(
        input logic [3:0]            sel,
        input logic [DATA_WIDTH-1:0] n_v,
        input logic [DATA_WIDTH-1:0] e_v,
        input logic [DATA_WIDTH-1:0] s_v,
        input logic [DATA_WIDTH-1:0] w_v,
        input logic [DATA_WIDTH-1:0] rf_v,
        input logic [DATA_WIDTH-1:0] imm_v,
        input logic [DATA_WIDTH-1:0] acc_v,
        input logic [DATA_WIDTH-1:0] spm_v
    );
        case (sel)
            4'd1:    src_mux = n_v;
            4'd2:    src_mux = e_v;
            4'd3:    src_mux = s_v;
            4'd4:    src_mux = w_v;
            4'd5:    src_mux = rf_v;
            4'd6:    src_mux = imm_v;
            4'd7:    src_mux = acc_v;
            4'd8:    src_mux = spm_v;
            default: src_mux = {DATA_WIDTH{1'b0}};
        endcase
    endfunction

    // A neighbour source is only usable when its valid is high; other sources are always ready.
    function automatic logic src_ready(input logic [3:0] sel, input logic [3:0] vin);
        case (sel)
            4'd1:    src_ready = vin[0];
            4'd2:    src_ready = vin[1];
            4'd3:    src_ready = vin[2];
            4'd4:    src_ready = vin[3];
            default: src_ready = 1'b1;
        endcase
    endfunction

    logic [5:0]            opcode_s;
    logic [3:0]            src0_sel_s;
    logic [3:0]            src1_sel_s;
    logic [3:0]            dst_s;
    logic [3:0]            route_s;
    logic                  pred_en_s;
    logic                  pred_inv_s;
    logic [15:0]           imm_s;
    logic [3:0]            rf_ridx_s;
    logic                  unused_reserved_s;

    logic [DATA_WIDTH-1:0] rf_q [RF_DEPTH];
    logic [DATA_WIDTH-1:0] spm_mem [SPM_DEPTH];
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic                  pred_q, pred_d;
    logic [DATA_WIDTH-1:0] local_data_q, local_data_d;
    logic                  local_valid_q, local_valid_d;
    logic [DATA_WIDTH-1:0] mesh_data_q [4];
    logic [DATA_WIDTH-1:0] mesh_data_d [4];
    logic [3:0]            mesh_valid_q, mesh_valid_d;

    logic [3:0]            vin_s;
    logic [DATA_WIDTH-1:0] a_s, b_s;
    logic [DATA_WIDTH-1:0] rf_rd_s, spm_imm_rd_s, spm_a_rd_s;
    logic                  fire_s;
    logic [DATA_WIDTH-1:0] result_s;
    logic                  has_result_s;
    logic                  rf_we_s;
    logic                  spm_we_s;
    logic [LW-1:0]         lif_sum_s;
    logic [LW-1:0]         lif_v_s;
    logic                  lif_spike_s;

    assign opcode_s          = config_frame[5:0];
    assign src0_sel_s        = config_frame[9:6];
    assign src1_sel_s        = config_frame[13:10];
    assign dst_s             = config_frame[17:14];
    assign route_s           = config_frame[21:18];
    assign pred_en_s         = config_frame[22];
    assign pred_inv_s        = config_frame[23];
    assign imm_s             = config_frame[39:24];
    assign rf_ridx_s         = config_frame[43:40];
    assign unused_reserved_s = ^config_frame[63:44];

    assign vin_s        = {valid_in_w, valid_in_s, valid_in_e, valid_in_n};
    assign rf_rd_s      = rf_q[rf_ridx_s];
    assign spm_imm_rd_s = spm_mem[imm_s[ADDR_WIDTH-1:0]];
    assign a_s = src_mux(src0_sel_s, data_in_n, data_in_e, data_in_s, data_in_w,
                         rf_rd_s, imm_s, acc_q, spm_imm_rd_s);
    assign b_s = src_mux(src1_sel_s, data_in_n, data_in_e, data_in_s, data_in_w,
                         rf_rd_s, imm_s, acc_q, spm_imm_rd_s);
    assign spm_a_rd_s = spm_mem[a_s[ADDR_WIDTH-1:0]];

    assign fire_s = config_valid
                  & src_ready(src0_sel_s, vin_s)
                  & src_ready(src1_sel_s, vin_s)
                  & (~pred_en_s | (pred_q == ~pred_inv_s));

    // Membrane update is evaluated two bits wider so the signed sum never wraps before the clamp.
    assign lif_sum_s   = {{2{acc_q[DATA_WIDTH-1]}}, acc_q} + {{2{a_s[DATA_WIDTH-1]}}, a_s}
                       - LW'(LIF_LEAK);
    assign lif_v_s     = lif_sum_s[LW-1] ? {LW{1'b0}} : lif_sum_s;
    assign lif_spike_s = (lif_v_s >= {2'b00, b_s});

    // Opcode execution: result, writeback enables and next accumulator/predicate.
    always_comb begin
        acc_d        = acc_q;
        pred_d       = pred_q;
        result_s     = {DATA_WIDTH{1'b0}};
        has_result_s = 1'b0;
        rf_we_s      = 1'b0;
        spm_we_s     = 1'b0;
        if (fire_s) begin
            has_result_s = 1'b1;
            rf_we_s      = 1'b1;
            case (opcode_s)
                OP_ADD:   result_s = a_s + b_s;
                OP_SUB:   result_s = a_s - b_s;
                OP_MUL:   result_s = a_s * b_s;
                OP_MAC: begin
                    acc_d    = acc_q + a_s * b_s;
                    result_s = acc_d;
                end
                OP_AND:   result_s = a_s & b_s;
                OP_OR:    result_s = a_s | b_s;
                OP_XOR:   result_s = a_s ^ b_s;
                OP_SHL:   result_s = a_s << b_s[3:0];
                OP_SHR:   result_s = a_s >> b_s[3:0];
                OP_CMP_GT, OP_CMP_LT, OP_CMP_EQ: begin
                    rf_we_s = 1'b0;
                    if (opcode_s == OP_CMP_GT) begin
                        pred_d = (a_s > b_s);
                    end else if (opcode_s == OP_CMP_LT) begin
                        pred_d = (a_s < b_s);
                    end else begin
                        pred_d = (a_s == b_s);
                    end
                    result_s = {{(DATA_WIDTH-1){1'b0}}, pred_d};
                end
                OP_LOAD:  result_s = spm_a_rd_s;
                OP_STORE: begin
                    spm_we_s     = 1'b1;
                    has_result_s = 1'b0;
                    rf_we_s      = 1'b0;
                end
                OP_ACC_CLR: begin
                    acc_d        = {DATA_WIDTH{1'b0}};
                    has_result_s = 1'b0;
                    rf_we_s      = 1'b0;
                end
                OP_PASS0: result_s = a_s;
                OP_PASS1: result_s = b_s;
                OP_LIF: begin
                    rf_we_s = 1'b0;
                    if (lif_spike_s) begin
                        result_s = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
                        acc_d    = {DATA_WIDTH{1'b0}};
                    end else begin
                        result_s = {DATA_WIDTH{1'b0}};
                        acc_d    = lif_v_s[DATA_WIDTH-1:0];
                    end
                end
                default: begin
                    has_result_s = 1'b0;
                    rf_we_s      = 1'b0;
                end
            endcase
        end else begin
            has_result_s = 1'b0;
        end
    end

    // Output steering: valids pulse for one cycle, data holds when nothing is delivered.
    always_comb begin
        if (has_result_s) begin
            local_data_d  = result_s;
            local_valid_d = 1'b1;
        end else begin
            local_data_d  = local_data_q;
            local_valid_d = 1'b0;
        end
        for (int i = 0; i < 4; i++) begin
            if (has_result_s && route_s[i]) begin
                mesh_data_d[i]  = result_s;
                mesh_valid_d[i] = 1'b1;
            end else begin
                mesh_data_d[i]  = mesh_data_q[i];
                mesh_valid_d[i] = 1'b0;
            end
        end
    end

    // Architectural state and output registers; reset wins over any firing frame.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            acc_q         <= {DATA_WIDTH{1'b0}};
            pred_q        <= 1'b0;
            local_data_q  <= {DATA_WIDTH{1'b0}};
            local_valid_q <= 1'b0;
            mesh_valid_q  <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                mesh_data_q[i] <= {DATA_WIDTH{1'b0}};
            end
            for (int i = 0; i < RF_DEPTH; i++) begin
                rf_q[i] <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            acc_q         <= acc_d;
            pred_q        <= pred_d;
            local_data_q  <= local_data_d;
            local_valid_q <= local_valid_d;
            mesh_valid_q  <= mesh_valid_d;
            for (int i = 0; i < 4; i++) begin
                mesh_data_q[i] <= mesh_data_d[i];
            end
            if (rf_we_s) begin
                rf_q[dst_s] <= result_s;
            end
        end
    end

    // Scratchpad write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (!rst_n && spm_we_s) begin
            spm_mem[a_s[ADDR_WIDTH-1:0]] <= b_s;
        end
    end

    assign data_out_local  = local_data_q;
    assign valid_out_local = local_valid_q;
    assign data_out_n      = mesh_data_q[0];
    assign data_out_e      = mesh_data_q[1];
    assign data_out_s      = mesh_data_q[2];
    assign data_out_w      = mesh_data_q[3];
    assign valid_out_n     = mesh_valid_q[0];
    assign valid_out_e     = mesh_valid_q[1];
    assign valid_out_s     = mesh_valid_q[2];
    assign valid_out_w     = mesh_valid_q[3];

endmodule

// File: tb/tb_cgra_pe_unit.sv
// Self-checking bench for cgra_pe_unit: directed scenarios plus randomized frames
// checked against a behavioural PE model.
module tb_cgra_pe_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] config_frame;
    logic        config_valid;
    logic [15:0] data_in_n, data_in_e, data_in_s, data_in_w;
    logic        valid_in_n, valid_in_e, valid_in_s, valid_in_w;
    logic [15:0] data_out_n, data_out_e, data_out_s, data_out_w, data_out_local;
    logic        valid_out_n, valid_out_e, valid_out_s, valid_out_w, valid_out_local;

    always #5 clk = ~clk;

    cgra_pe_unit dut (
        .clk(clk), .rst_n(rst_n), .config_frame(config_frame), .config_valid(config_valid),
        .data_in_n(data_in_n), .data_in_e(data_in_e), .data_in_s(data_in_s), .data_in_w(data_in_w),
        .valid_in_n(valid_in_n), .valid_in_e(valid_in_e), .valid_in_s(valid_in_s),
        .valid_in_w(valid_in_w),
        .data_out_n(data_out_n), .data_out_e(data_out_e), .data_out_s(data_out_s),
        .data_out_w(data_out_w),
        .valid_out_n(valid_out_n), .valid_out_e(valid_out_e), .valid_out_s(valid_out_s),
        .valid_out_w(valid_out_w),
        .data_out_local(data_out_local), .valid_out_local(valid_out_local)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural state of the PE; index 0 of e_* is local, 1..4 are N,E,S,W.
    logic [15:0] m_rf [16];
    logic [15:0] m_spm [256];
    logic [15:0] m_acc;
    logic        m_pred;
    logic [15:0] e_data [5];
    logic        e_valid [5];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mk(input int op, input int s0, input int s1, input int dst,
                                       input int route, input int pen, input int pinv,
                                       input int imm, input int ridx);
        logic [63:0] f;
        f        = 64'd0;
        f[5:0]   = op[5:0];
        f[9:6]   = s0[3:0];
        f[13:10] = s1[3:0];
        f[17:14] = dst[3:0];
        f[21:18] = route[3:0];
        f[22]    = pen[0];
        f[23]    = pinv[0];
        f[39:24] = imm[15:0];
        f[43:40] = ridx[3:0];
        return f;
    endfunction

    function automatic logic [15:0] m_val(input int sel);
        case (sel)
            1: return data_in_n;
            2: return data_in_e;
            3: return data_in_s;
            4: return data_in_w;
            5: return m_rf[config_frame[43:40]];
            6: return config_frame[39:24];
            7: return m_acc;
            8: return m_spm[config_frame[31:24]];
            default: return 16'd0;
        endcase
    endfunction

    function automatic bit m_rdy(input int sel);
        case (sel)
            1: return valid_in_n;
            2: return valid_in_e;
            3: return valid_in_s;
            4: return valid_in_w;
            default: return 1'b1;
        endcase
    endfunction

    task automatic model_cycle(input bit rst);
        int op, s0, s1, ai, bi, v;
        logic [15:0] a, b, r;
        bit fire, has, wr;
        for (int i = 0; i < 5; i++) e_valid[i] = 1'b0;
        if (rst) begin
            for (int i = 0; i < 16; i++) m_rf[i] = 16'd0;
            for (int i = 0; i < 5; i++) e_data[i] = 16'd0;
            m_acc  = 16'd0;
            m_pred = 1'b0;
            return;
        end
        op = int'(config_frame[5:0]);
        s0 = int'(config_frame[9:6]);
        s1 = int'(config_frame[13:10]);
        a  = m_val(s0);
        b  = m_val(s1);
        ai = int'(a);
        bi = int'(b);
        fire = config_valid && m_rdy(s0) && m_rdy(s1)
               && (!config_frame[22] || (m_pred != config_frame[23]));
        if (!fire) return;
        has = 1'b1;
        wr  = 1'b1;
        r   = 16'd0;
        case (op)
            1:  r = 16'(ai + bi);
            2:  r = 16'(ai - bi);
            3:  r = 16'(ai * bi);
            4:  begin m_acc = 16'(int'(m_acc) + ai * bi); r = m_acc; end
            5:  r = a & b;
            6:  r = a | b;
            7:  r = a ^ b;
            8:  r = 16'(ai << b[3:0]);
            9:  r = 16'(ai >> b[3:0]);
            10: begin r = (ai > bi) ? 16'd1 : 16'd0; m_pred = r[0]; wr = 1'b0; end
            11: begin r = (ai < bi) ? 16'd1 : 16'd0; m_pred = r[0]; wr = 1'b0; end
            12: begin r = (ai == bi) ? 16'd1 : 16'd0; m_pred = r[0]; wr = 1'b0; end
            13: r = m_spm[a[7:0]];
            14: begin m_spm[a[7:0]] = b; has = 1'b0; end
            15: begin m_acc = 16'd0; has = 1'b0; end
            16: r = a;
            17: r = b;
            18: begin
                v = int'($signed(m_acc)) + int'($signed(a)) - 10;
                if (v < 0) v = 0;
                if (v >= bi) begin r = 16'd1; m_acc = 16'd0; end
                else begin r = 16'd0; m_acc = 16'(v); end
                wr = 1'b0;
            end
            default: has = 1'b0;
        endcase
        if (has) begin
            e_valid[0] = 1'b1;
            e_data[0]  = r;
            if (wr) m_rf[config_frame[17:14]] = r;
            for (int i = 0; i < 4; i++) begin
                if (config_frame[18+i]) begin
                    e_valid[i+1] = 1'b1;
                    e_data[i+1]  = r;
                end
            end
        end
    endtask

    task automatic run_cycle(input bit rst, input logic [63:0] f, input bit fv,
                             input logic [15:0] dn, input logic [15:0] de,
                             input logic [15:0] ds, input logic [15:0] dw,
                             input logic [3:0] vin);
        rst_n        = rst;
        config_frame = f;
        config_valid = fv;
        data_in_n = dn; data_in_e = de; data_in_s = ds; data_in_w = dw;
        {valid_in_w, valid_in_s, valid_in_e, valid_in_n} = vin;
        model_cycle(rst);
        @(posedge clk);
        #1;
        chk("valid_local", 32'(valid_out_local), 32'(e_valid[0]));
        chk("data_local",  32'(data_out_local),  32'(e_data[0]));
        chk("valid_n", 32'(valid_out_n), 32'(e_valid[1]));
        chk("data_n",  32'(data_out_n),  32'(e_data[1]));
        chk("valid_e", 32'(valid_out_e), 32'(e_valid[2]));
        chk("data_e",  32'(data_out_e),  32'(e_data[2]));
        chk("valid_s", 32'(valid_out_s), 32'(e_valid[3]));
        chk("data_s",  32'(data_out_s),  32'(e_data[3]));
        chk("valid_w", 32'(valid_out_w), 32'(e_valid[4]));
        chk("data_w",  32'(data_out_w),  32'(e_data[4]));
    endtask

    task automatic go(input logic [63:0] f, input logic [15:0] dn, input logic [15:0] de,
                      input logic [3:0] vin);
        run_cycle(1'b0, f, 1'b1, dn, de, 16'd0, 16'd0, vin);
    endtask

    initial begin
        logic [63:0] f;
        logic [3:0]  vin;

        run_cycle(1'b1, 64'd0, 1'b0, 16'd0, 16'd0, 16'd0, 16'd0, 4'h0);
        chk("rst_valid_local", 32'(valid_out_local), 32'd0);
        chk("rst_data_local", 32'(data_out_local), 32'd0);

        // Give every scratchpad word a known value so later reads are defined.
        for (int a = 0; a < 256; a++) begin
            go(mk(14, 6, 1, 0, 0, 0, 0, a, 0), 16'($urandom), 16'd0, 4'hF);
        end

        run_cycle(1'b1, 64'd0, 1'b0, 16'd0, 16'd0, 16'd0, 16'd0, 4'h0);
        go(mk(1, 6, 1, 0, 0, 0, 0, 10, 0), 16'd20, 16'd0, 4'hF);
        chk("add_30", 32'(data_out_local), 32'd30);
        chk("add_valid", 32'(valid_out_local), 32'd1);
        go(mk(16, 5, 0, 1, 0, 0, 0, 0, 0), 16'd0, 16'd0, 4'hF);
        chk("rf0_30", 32'(data_out_local), 32'd30);

        run_cycle(1'b1, 64'd0, 1'b0, 16'd0, 16'd0, 16'd0, 16'd0, 4'h0);
        go(mk(4, 1, 2, 2, 0, 0, 0, 0, 0), 16'd2, 16'd3, 4'hF);
        chk("mac_6", 32'(data_out_local), 32'd6);
        go(mk(4, 1, 2, 2, 0, 0, 0, 0, 0), 16'd4, 16'd5, 4'hF);
        chk("mac_26", 32'(data_out_local), 32'd26);

        go(mk(10, 6, 1, 0, 0, 0, 0, 10, 0), 16'd5, 16'd0, 4'hF);
        chk("cmp_gt", 32'(data_out_local), 32'd1);
        go(mk(1, 6, 1, 2, 0, 1, 0, 100, 0), 16'd50, 16'd0, 4'hF);
        chk("pred_add", 32'(data_out_local), 32'd150);
        go(mk(1, 6, 1, 2, 0, 1, 1, 100, 0), 16'd50, 16'd0, 4'hF);
        chk("pred_inv_block", 32'(valid_out_local), 32'd0);

        go(mk(16, 6, 0, 3, 15, 0, 0, 16'hABCD, 0), 16'd0, 16'd0, 4'hF);
        chk("route_w", 32'(data_out_w), 32'hABCD);
        chk("route_n_valid", 32'(valid_out_n), 32'd1);

        go(mk(15, 0, 0, 0, 0, 0, 0, 0, 0), 16'd0, 16'd0, 4'hF);
        chk("accclr_novalid", 32'(valid_out_local), 32'd0);
        go(mk(18, 1, 6, 9, 0, 0, 0, 100, 0), 16'd50, 16'd0, 4'hF);
        chk("lif_0", 32'(data_out_local), 32'd0);
        go(mk(16, 7, 0, 9, 0, 0, 0, 0, 0), 16'd0, 16'd0, 4'hF);
        chk("lif_acc40", 32'(data_out_local), 32'd40);
        go(mk(18, 1, 6, 9, 0, 0, 0, 100, 0), 16'd80, 16'd0, 4'hF);
        chk("lif_spike", 32'(data_out_local), 32'd1);
        go(mk(16, 7, 0, 9, 0, 0, 0, 0, 0), 16'd0, 16'd0, 4'hF);
        chk("lif_acc0", 32'(data_out_local), 32'd0);

        go(mk(4, 6, 6, 4, 0, 0, 0, 3, 0), 16'd0, 16'd0, 4'hF);
        go(mk(4, 1, 6, 5, 15, 0, 0, 3, 0), 16'd7, 16'd0, 4'b1110);
        chk("stall_novalid", 32'(valid_out_local), 32'd0);
        go(mk(16, 7, 0, 6, 0, 0, 0, 0, 0), 16'd0, 16'd0, 4'hF);
        chk("stall_acc9", 32'(data_out_local), 32'd9);
        go(mk(16, 5, 0, 6, 0, 0, 0, 0, 5), 16'd0, 16'd0, 4'hF);
        chk("stall_rf5", 32'(data_out_local), 32'd0);

        go(mk(14, 6, 1, 0, 0, 0, 0, 3, 0), 16'h0055, 16'd0, 4'hF);
        go(mk(13, 6, 0, 7, 0, 0, 0, 3, 0), 16'd0, 16'd0, 4'hF);
        chk("load_55", 32'(data_out_local), 32'h55);

        // Randomized frames against the model, with occasional resets.
        for (int i = 0; i < 800; i++) begin
            f = mk($urandom_range(0, 22),
                   ($urandom_range(0, 7) == 0) ? $urandom_range(9, 15) : $urandom_range(0, 8),
                   ($urandom_range(0, 7) == 0) ? $urandom_range(9, 15) : $urandom_range(0, 8),
                   $urandom_range(0, 15), $urandom_range(0, 15),
                   ($urandom_range(0, 3) == 0) ? 1 : 0, $urandom_range(0, 1),
                   $urandom_range(0, 65535), $urandom_range(0, 15));
            f[63:44] = 20'($urandom);
            for (int k = 0; k < 4; k++) vin[k] = ($urandom_range(0, 4) != 0);
            run_cycle(($urandom_range(0, 149) == 0), f, ($urandom_range(0, 9) != 0),
                      16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), vin);
        end

        go(mk(4, 6, 6, 4, 0, 0, 0, 5, 0), 16'd0, 16'd0, 4'hF);
        run_cycle(1'b1, mk(4, 6, 6, 4, 15, 0, 0, 5, 0), 1'b1,
                  16'd0, 16'd0, 16'd0, 16'd0, 4'hF);
        chk("midrst_valid", 32'(valid_out_local), 32'd0);
        chk("midrst_data", 32'(data_out_local), 32'd0);
        go(mk(16, 7, 0, 0, 0, 0, 0, 0, 0), 16'd0, 16'd0, 4'hF);
        chk("midrst_acc0", 32'(data_out_local), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cgra_pe_unit.md
# cgra_pe_unit

Single processing element of the CGRA fabric: one 64-bit configuration frame per cycle selects an opcode, two operand sources, a register-file destination and an output route. Four mesh neighbours (N/E/S/W) feed operands. Results leave through registered mesh outputs and a local output. Each PE holds a register file, a scratchpad memory, an accumulator/membrane register and a predicate bit, and supports a hardware leaky-integrate-and-fire (LIF) step.

## Interface
- DATA_WIDTH, 16: datapath width.
- ADDR_WIDTH, 8: scratchpad address width.
- SPM_DEPTH, 256: scratchpad words.
- RF_DEPTH, 16: register-file entries.
- LIF_LEAK, 10: constant leak subtracted per LIF step.
- clk  in  1  clock. One clock; all state changes on its rising edge.
- rst_n  in  1  reset. Synchronous, active-high: the PE resets on a rising edge where rst_n = 1.
- config_frame  in  64  instruction word.
- config_valid  in  1  execute config_frame this cycle.
- data_in_n/e/s/w  in  DATA_WIDTH each  neighbour operands.
- valid_in_n/e/s/w  in  1 each  neighbour operand valid.
- data_out_n/e/s/w  out  DATA_WIDTH each  routed result.
- valid_out_n/e/s/w  out  1 each  routed result valid.
- data_out_local, valid_out_local  out  DATA_WIDTH, 1  local result.

## Operation
- Frame fields: [5:0] opcode; [9:6] src0 select; [13:10] src1 select; [17:14] dst RF index; [21:18] route mask (bit0 N, bit1 E, bit2 S, bit3 W); [22] pred_en; [23] pred_inv; [39:24] immediate; [43:40] RF read index; [63:44] reserved, ignored.
- Source select:
  - 0 = zero; 1 = N, 2 = E, 3 = S, 4 = W.
  - 5 = RF[frame[43:40]]; 6 = immediate; 7 = accumulator.
  - 8 = SPM[immediate[ADDR_WIDTH-1:0]].
  - 9–15 = zero.
- Fire condition: config_valid = 1, AND every selected neighbour source has its valid_in = 1, AND (pred_en = 0 or pred == ~pred_inv). If any condition fails: no state change and all valids are 0 next cycle.
- Opcodes (arithmetic modulo 2^16, compares unsigned):
  - 0 NOP (no result).
  - 1 ADD a+b; 2 SUB a−b; 3 MUL low 16 bits of a*b.
  - 4 MAC acc <= acc + a*b; result = new acc.
  - 5 AND; 6 OR; 7 XOR.
  - 8 SHL a<<b[3:0]; 9 SHR logical a>>b[3:0].
  - 10 CMP_GT, 11 CMP_LT, 12 CMP_EQ: result is 1/0 and is also written to pred.
  - 13 LOAD SPM[a[ADDR_WIDTH-1:0]].
  - 14 STORE SPM[a] <= b (no result).
  - 15 ACC_CLR acc <= 0 (no result).
  - 16 PASS0 a; 17 PASS1 b.
  - 18 LIF: v = acc + a − LIF_LEAK, computed signed and clamped at 0. If v ≥ b (threshold): result 1 and acc <= 0; else result 0 and acc <= v.
  - 19–63 NOP.
- Writeback: ops producing a result, except LIF and compares, write the result to RF[dst].
- Local output: valid_out_local = 1 and data_out_local = result for every fired result-producing op.
- Mesh outputs: each direction whose route-mask bit is set gets the same result and valid.
- Unrouted or non-firing outputs: valid 0; data holds its previous value.
- pred changes only on compares and reset.

## Timing
- Single-cycle execute: the frame sampled at edge k produces registered outputs visible after edge k.
- valid_out_* are one-cycle pulses per fired op. Back-to-back frames produce back-to-back results.
- SPM read is combinational within the cycle. A LOAD to an address after a STORE to the same address in the previous cycle returns the new value.
- The accumulator updates at the same edge the result registers.
- Reset values: all data_out_* = 0, all valid_out_* = 0, acc = 0, pred = 0, RF = 0. SPM is not reset.
- Reset asserted mid-operation overrides any firing frame in that cycle.

## Test plan
- ADD: src0 = immediate 10, src1 = N = 20 (valid), route 0 → one cycle later data_out_local = 30, valid_out_local = 1, RF[0] = 30.
- MAC after reset: (2,3) then (4,5) on consecutive cycles → local outputs 6, then 26.
- CMP_GT 10 > 5 → local output 1, pred = 1. Then ADD with pred_en = 1, pred_inv = 0, 100 + 50 → 150. Same frame with pred_inv = 1 → no valid.
- PASS0 immediate 0xABCD, route mask 1111 → next cycle all four valid_out_* = 1 and data = 0xABCD.
- LIF: ACC_CLR, then threshold 100 with N = 50 → output 0 (acc = 40). Next cycle N = 80 → output 1, acc = 0.
- Stall: src0 = N with valid_in_n = 0 → no valids, no RF/acc change. STORE 0x55 to address 3, then LOAD address 3 → 0x55.
